cpu_phase_sequencer: RTL and testbench
======================================

Name: cpu_phase_sequencer

Overview:
Generates the CPU clock and per-cycle phase timing from the fast memory clock, for single-cycle and multi-cycle cores in the exercise designs. Generalises the fixed divide-by-4 / "write only in second half" scheme to a parametrised ratio, N gated write channels, memory/IO wait states, and run/single-step control. Sits at top level between the base clock, CPU, IMem/DMem and IOCtrl.

Parameters:
RATIO, 4, base-clock cycles per CPU cycle; even, >= 2
NUM_CH, 2, number of gated write-enable channels (ch0 DMem, ch1 IOCtrl)
WE_START, RATIO/2, first phase in which write strobes may assert
WE_END, RATIO-1, last phase in which write strobes may assert; WE_START <= WE_END < RATIO
MAX_WAIT, 7, wait-state limit per CPU cycle before forced completion

Ports:
clk  in  1  base (fast) clock; all state on rising edge
rst  in  1  synchronous reset, active-high
run  in  1  1 = free-running; 0 = halt at next CPU-cycle boundary
stepReq  in  1  while halted, 1-cycle pulse executes exactly one CPU cycle
waitReq  in  1  memory/IO not ready; sampled in last phase only
weReq  in  NUM_CH  per-channel write request from CPU
cpuClk  out  1  generated CPU clock
cpuTick  out  1  1-cycle pulse when a CPU cycle commits
phase  out  $clog2(RATIO)  current phase
weOut  out  NUM_CH  gated write strobes to memories/IO
busy  out  1  1 in RUN, STEP, WAIT
waitTimeout  out  1  sticky: a wait hit MAX_WAIT
cycleCount  out  32  committed CPU cycles, wraps
stallCount  out  16  total wait cycles, saturates at 16'hFFFF

Behaviour:
- States: IDLE, RUN, STEP, WAIT. Reset -> IDLE, phase=0, waitCnt=0, cycleCount=0, stallCount=0, waitTimeout=0.
- Reset outputs: cpuClk=0, cpuTick=0, weOut=0, busy=0. rst mid-cycle aborts immediately; no strobe or tick in the reset cycle or the one after.
- Outputs are Moore-decoded from registered state/phase; weOut additionally ANDs weReq combinationally (zero latency from weReq).
- cpuClk = 1 in phases 0..RATIO/2-1 of RUN/STEP, else 0; forced 0 in IDLE and WAIT.
- weOut[i] = weReq[i] && state in {RUN, STEP} && WE_START <= phase <= WE_END. Always 0 in IDLE/WAIT (no repeated IO writes during stalls).
- IDLE: run=1 -> RUN, phase 0. Else stepReq=1 -> STEP. If both, run wins.
- RUN/STEP: phase++ each clk. At phase RATIO-1:
  - waitReq=1 -> WAIT, phase held at RATIO-1, waitCnt=0.
  - else cpuTick=1 on this clk, cycleCount++, phase->0; next state RUN if (state==RUN && run) else IDLE.
- WAIT: waitCnt++ and stallCount++ (saturating) each clk. Exit when waitReq=0 or waitCnt==MAX_WAIT-1 (timeout also sets waitTimeout). Exit clk: cpuTick=1, cycleCount++, phase->0; next RUN if run else IDLE (a STEP-originated wait returns to IDLE whenever run=0).
- run dropping mid-cycle completes the current CPU cycle, then IDLE. stepReq ignored when not IDLE.
- Exactly one cpuTick per CPU cycle; nominal period RATIO clks, RATIO+k with k wait cycles.

Decomposition:
- Package (CpuSeqTypes): SeqState enum, PhasePath typedef, default RATIO/NUM_CH/MAX_WAIT constants, shared with Main-level top and bench.
- Sub-module: phase_counter (mod-RATIO counter with hold and clear), instantiated once; FSM, strobe gating and statistics in the parent.

Test Plan:
- Reset, run=1, waitReq=0, RATIO=4 -> cpuClk pattern 1100 repeating; cpuTick on every phase 3; cycleCount=10 after 40 clks.
- weReq=2'b11 held, RATIO=4 -> weOut=2'b11 only in phases 2,3; 2'b00 in phases 0,1.
- waitReq=1 for 3 clks at phase 3 -> WAIT 3 clks, cpuClk=0, weOut=0, tick once at exit, stallCount=3, CPU period 7.
- waitReq stuck 1, MAX_WAIT=7 -> forced exit after 7 wait clks, waitTimeout=1 and stays 1 until rst.
- run=0, two stepReq pulses 10 clks apart -> exactly 2 cpuTicks, cycleCount=2, busy=0 between steps.
- rst asserted at phase 2 with weReq=1 -> weOut=0 next clk, state IDLE, all counters 0.

Source files
------------

// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared types and default constants for the CPU phase sequencer and its bench.
package cpu_phase_sequencer_pkg;

    localparam int unsigned DEF_RATIO    = 4;
    localparam int unsigned DEF_NUM_CH   = 2;
    localparam int unsigned DEF_MAX_WAIT = 7;
    localparam int unsigned DEF_PHASE_W  = $clog2(DEF_RATIO);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_WAIT = 2'd3
    } seq_state_t;

    typedef logic [DEF_PHASE_W-1:0] phase_path_t;

    // Bit i set when phase i lies in [lo, hi]; phases beyond 31 are not representable.
    function automatic logic [31:0] phase_window(input int unsigned lo, input int unsigned hi);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            m[i] = (i >= lo) && (i <= hi);
        end
        return m;
    endfunction

endpackage

// File: rtl/cpu_phase_sequencer_phase_counter.sv
// Modulo-RATIO phase counter with clear and advance; holds when advance is low.
module cpu_phase_sequencer_phase_counter #(
    parameter int unsigned RATIO = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     advance,
    output logic [$clog2(RATIO)-1:0] phase
);

    localparam int unsigned PHASE_W = $clog2(RATIO);
    localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(RATIO - 1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            phase <= '0;
        end else if (advance) begin
            phase <= (phase == PH_LAST) ? '0 : phase + PHASE_W'(1);
        end
    end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Derives CPU clock, commit tick and gated write strobes from the fast base clock,
// with wait-state stretching, run/single-step control and cycle statistics.
module cpu_phase_sequencer
    import cpu_phase_sequencer_pkg::*;
#(
    parameter int unsigned RATIO    = DEF_RATIO,
    parameter int unsigned NUM_CH   = DEF_NUM_CH,
    parameter int unsigned WE_START = RATIO / 2,
    parameter int unsigned WE_END   = RATIO - 1,
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     stepReq,
    input  logic                     waitReq,
    input  logic [NUM_CH-1:0]        weReq,
    output logic                     cpuClk,
    output logic                     cpuTick,
    output logic [$clog2(RATIO)-1:0] phase,
    output logic [NUM_CH-1:0]        weOut,
    output logic                     busy,
    output logic                     waitTimeout,
    output logic [31:0]              cycleCount,
    output logic [15:0]              stallCount
);

    localparam int unsigned PHASE_W = $clog2(RATIO);
    localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam logic [PHASE_W-1:0] PH_LAST   = PHASE_W'(RATIO - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [31:0] CLK_MASK = phase_window(0, RATIO / 2 - 1);
    localparam logic [31:0] WE_MASK  = phase_window(WE_START, WE_END);

    seq_state_t         state, next_state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               commit, enter_wait, timeout, advance, in_cycle;

    cpu_phase_sequencer_phase_counter #(
        .RATIO (RATIO)
    ) u_phase (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_IDLE),
        .advance (advance),
        .phase   (phase)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, commit decode and Moore outputs; reset masks every strobe.
    always_comb begin
        next_state = state;
        commit     = 1'b0;
        enter_wait = 1'b0;
        timeout    = 1'b0;
        advance    = 1'b0;
        in_cycle   = (state == ST_RUN) || (state == ST_STEP);

        case (state)
            ST_IDLE: begin
                if (run) begin
                    next_state = ST_RUN;
                end else if (stepReq) begin
                    next_state = ST_STEP;
                end
            end
            ST_RUN, ST_STEP: begin
                advance = 1'b1;
                if (phase == PH_LAST) begin
                    if (waitReq) begin
                        enter_wait = 1'b1;
                        advance    = 1'b0;
                        next_state = ST_WAIT;
                    end else begin
                        commit     = 1'b1;
                        next_state = (state == ST_RUN && run) ? ST_RUN : ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                if (!waitReq || wait_cnt == WAIT_LAST) begin
                    commit     = 1'b1;
                    advance    = 1'b1;
                    timeout    = waitReq;
                    next_state = run ? ST_RUN : ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase

        cpuClk  = !rst && in_cycle && CLK_MASK[phase];
        cpuTick = !rst && commit;
        busy    = !rst && (state != ST_IDLE);
        weOut   = weReq & {NUM_CH{!rst && in_cycle && WE_MASK[phase]}};
    end

    // Wait-state counter and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            cycleCount  <= '0;
            stallCount  <= '0;
            waitTimeout <= 1'b0;
        end else begin
            if (enter_wait) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
                if (stallCount != 16'hFFFF) begin
                    stallCount <= stallCount + 16'd1;
                end
            end
            if (commit) begin
                cycleCount <= cycleCount + 32'd1;
            end
            if (timeout) begin
                waitTimeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed bench for cpu_phase_sequencer at RATIO=4, two channels, MAX_WAIT=7.
module tb_cpu_phase_sequencer;
    import cpu_phase_sequencer_pkg::*;

    logic        clk;
    logic        rst, run, stepReq, waitReq;
    logic [1:0]  weReq;
    logic        cpuClk, cpuTick, busy, waitTimeout;
    phase_path_t phase;
    logic [1:0]  weOut;
    logic [31:0] cycleCount;
    logic [15:0] stallCount;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       run;
        logic       step;
        logic       wreq;
        logic [1:0] we;
        logic       e_clk;
        logic       e_tick;
        logic [1:0] e_ph;
        logic [1:0] e_we;
        logic       e_busy;
    } vec_t;

    vec_t vecs [25];

    cpu_phase_sequencer #(
        .RATIO    (4),
        .NUM_CH   (2),
        .WE_START (2),
        .WE_END   (3),
        .MAX_WAIT (7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .stepReq     (stepReq),
        .waitReq     (waitReq),
        .weReq       (weReq),
        .cpuClk      (cpuClk),
        .cpuTick     (cpuTick),
        .phase       (phase),
        .weOut       (weOut),
        .busy        (busy),
        .waitTimeout (waitTimeout),
        .cycleCount  (cycleCount),
        .stallCount  (stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic w, input logic [1:0] we);
        run     = r;
        stepReq = s;
        waitReq = w;
        weReq   = we;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        next_edge();
        rst = 1'b0;
    endtask

    initial begin
        int ticks, t_prev, period, found;

        // Rows: run, step, waitReq, weReq | cpuClk, cpuTick, phase, weOut, busy
        vecs[0]  = '{0, 0, 0, 2'b11, 0, 0, 2'd0, 2'b00, 0};
        vecs[1]  = '{1, 0, 0, 2'b11, 0, 0, 2'd0, 2'b00, 0};
        vecs[2]  = '{1, 0, 0, 2'b11, 1, 0, 2'd0, 2'b00, 1};
        vecs[3]  = '{1, 0, 0, 2'b11, 1, 0, 2'd1, 2'b00, 1};
        vecs[4]  = '{1, 0, 0, 2'b11, 0, 0, 2'd2, 2'b11, 1};
        vecs[5]  = '{1, 0, 0, 2'b11, 0, 1, 2'd3, 2'b11, 1};
        vecs[6]  = '{1, 0, 0, 2'b01, 1, 0, 2'd0, 2'b00, 1};
        vecs[7]  = '{1, 0, 0, 2'b10, 1, 0, 2'd1, 2'b00, 1};
        vecs[8]  = '{1, 0, 0, 2'b10, 0, 0, 2'd2, 2'b10, 1};
        vecs[9]  = '{1, 0, 1, 2'b01, 0, 0, 2'd3, 2'b01, 1};
        vecs[10] = '{1, 0, 1, 2'b11, 0, 0, 2'd3, 2'b00, 1};
        vecs[11] = '{1, 0, 0, 2'b11, 0, 1, 2'd3, 2'b00, 1};
        vecs[12] = '{0, 0, 0, 2'b00, 1, 0, 2'd0, 2'b00, 1};
        vecs[13] = '{0, 0, 0, 2'b11, 1, 0, 2'd1, 2'b00, 1};
        vecs[14] = '{0, 0, 0, 2'b11, 0, 0, 2'd2, 2'b11, 1};
        vecs[15] = '{0, 0, 0, 2'b11, 0, 1, 2'd3, 2'b11, 1};
        vecs[16] = '{0, 0, 0, 2'b11, 0, 0, 2'd0, 2'b00, 0};
        vecs[17] = '{0, 1, 0, 2'b11, 0, 0, 2'd0, 2'b00, 0};
        vecs[18] = '{0, 0, 0, 2'b11, 1, 0, 2'd0, 2'b00, 1};
        vecs[19] = '{0, 1, 0, 2'b11, 1, 0, 2'd1, 2'b00, 1};
        vecs[20] = '{0, 0, 0, 2'b11, 0, 0, 2'd2, 2'b11, 1};
        vecs[21] = '{0, 0, 0, 2'b11, 0, 1, 2'd3, 2'b11, 1};
        vecs[22] = '{0, 0, 0, 2'b11, 0, 0, 2'd0, 2'b00, 0};
        vecs[23] = '{1, 1, 0, 2'b11, 0, 0, 2'd0, 2'b00, 0};
        vecs[24] = '{1, 0, 0, 2'b11, 1, 0, 2'd0, 2'b00, 1};

        do_reset();
        check("rst_cycle_count", cycleCount, 32'd0);
        check("rst_stall_count", 32'(stallCount), 32'd0);
        check("rst_timeout", 32'(waitTimeout), 32'd0);

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].run, vecs[i].step, vecs[i].wreq, vecs[i].we);
            @(negedge clk);
            check($sformatf("vec%0d_cpuclk", i), 32'(cpuClk), 32'(vecs[i].e_clk));
            check($sformatf("vec%0d_tick", i), 32'(cpuTick), 32'(vecs[i].e_tick));
            check($sformatf("vec%0d_phase", i), 32'(phase), 32'(vecs[i].e_ph));
            check($sformatf("vec%0d_weout", i), 32'(weOut), 32'(vecs[i].e_we));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            next_edge();
        end
        check("vec_cycle_count", cycleCount, 32'd4);
        check("vec_stall_count", 32'(stallCount), 32'd2);
        check("vec_timeout", 32'(waitTimeout), 32'd0);

        // Free run: 1100 clock pattern, tick on phase 3, ten cycles in 40 clks.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        next_edge();
        ticks = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("free_cpuclk", 32'(cpuClk), 32'((c % 4) < 2));
            check("free_tick", 32'(cpuTick), 32'((c % 4) == 3));
            if (cpuTick) ticks++;
            next_edge();
        end
        check("free_cycle_count", cycleCount, 32'd10);
        check("free_tick_total", 32'(ticks), 32'd10);

        // Three wait clocks stretch one CPU cycle to seven base clocks.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 2'b11);
        next_edge();
        t_prev = -1;
        period = 0;
        for (int c = 0; c <= 10; c++) begin
            waitReq = (c >= 7 && c <= 9);
            @(negedge clk);
            check("wait_tick", 32'(cpuTick), 32'(c == 3 || c == 10));
            check("wait_cpuclk", 32'(cpuClk), 32'(c < 8 && (c % 4) < 2));
            check("wait_weout", 32'(weOut), (c < 8 && (c % 4) >= 2) ? 32'd3 : 32'd0);
            check("wait_phase", 32'(phase), (c < 8) ? 32'(c % 4) : 32'd3);
            check("wait_busy", 32'(busy), 32'd1);
            if (cpuTick) begin
                if (t_prev >= 0) period = c - t_prev;
                t_prev = c;
            end
            next_edge();
        end
        waitReq = 1'b0;
        check("wait_stall_count", 32'(stallCount), 32'd3);
        check("wait_period", 32'(period), 32'd7);
        check("wait_cycle_count", cycleCount, 32'd2);

        // Stuck waitReq: forced exit after seven wait clocks, sticky timeout.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 2'b11);
        next_edge();
        for (int c = 0; c <= 12; c++) begin
            waitReq = (c >= 3);
            @(negedge clk);
            check("tmo_tick", 32'(cpuTick), 32'(c == 10));
            check("tmo_flag", 32'(waitTimeout), 32'(c >= 11));
            check("tmo_weout", 32'(weOut), (c == 2 || c == 3) ? 32'd3 : 32'd0);
            next_edge();
        end
        check("tmo_stall_count", 32'(stallCount), 32'd7);
        waitReq = 1'b0;
        for (int c = 0; c < 8; c++) next_edge();
        check("tmo_sticky", 32'(waitTimeout), 32'd1);

        // Reset mid-cycle at phase 2 with writes requested.
        found = 0;
        for (int k = 0; k < 8 && found == 0; k++) begin
            @(negedge clk);
            if (phase == 2'd2) found = 1;
            else next_edge();
        end
        check("abort_find_phase2", 32'(found), 32'd1);
        rst   = 1'b1;
        weReq = 2'b11;
        #1;
        check("abort_we_rst_cycle", 32'(weOut), 32'd0);
        check("abort_tick_rst_cycle", 32'(cpuTick), 32'd0);
        next_edge();
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 2'b11);
        @(negedge clk);
        check("abort_weout", 32'(weOut), 32'd0);
        check("abort_tick", 32'(cpuTick), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_phase", 32'(phase), 32'd0);
        check("abort_cycle_count", cycleCount, 32'd0);
        check("abort_stall_count", 32'(stallCount), 32'd0);
        check("abort_timeout", 32'(waitTimeout), 32'd0);
        next_edge();

        // Two single steps ten clocks apart while halted.
        do_reset();
        ticks = 0;
        for (int d = 0; d <= 20; d++) begin
            stepReq = (d == 0 || d == 10);
            @(negedge clk);
            check("step_busy", 32'(busy), 32'((d >= 1 && d <= 4) || (d >= 11 && d <= 14)));
            check("step_tick", 32'(cpuTick), 32'(d == 4 || d == 14));
            if (cpuTick) ticks++;
            next_edge();
        end
        stepReq = 1'b0;
        check("step_tick_total", 32'(ticks), 32'd2);
        check("step_cycle_count", cycleCount, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
